mul8_seq: RTL

//   Sequential 8x8 unsigned shift-add multiplier; 16-bit product.

---
 rtl/mul8_seq_pkg.sv | 17 +
 rtl/mul8_seq_if.sv | 25 ++
 rtl/mul8_seq_rca8.sv | 23 ++
 rtl/mul8_seq.sv | 97 +++++++++
 4 files changed

// File: rtl/mul8_seq_pkg.sv
// Shared constants and FSM state type for the sequential 8x8 shift-add multiplier.
// Every other file of the multiplier imports this package.
package mul8_seq_pkg;

   localparam int unsigned Width = 8;
   localparam int unsigned ProdWidth = 2 * Width;

   // Value of count on the final RUN step; eight steps cover all multiplier bits.
   localparam logic [2:0] LastStep = 3'd7;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/mul8_seq_if.sv
// Operand/result handshake bundle for mul8_seq.
// The master drives operands and accepts results; the slave is the multiplier.
interface mul8_seq_if;
   import mul8_seq_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [Width-1:0]     a;
   logic [Width-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [ProdWidth-1:0] product;
   logic                 busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );

endinterface

// File: rtl/mul8_seq_rca8.sv
// 8-bit ripple-carry adder; computes the partial-product sum in each multiplier step.
// Ports follow the adder's established order: carry out, sum, a, b, carry in.
module mul8_seq_rca8 (
   output logic       cout,
   output logic [7:0] sum,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin
);

   logic [8:0] carry;

   always_comb begin
      carry[0] = cin;
      sum      = '0;
      for (int i = 0; i < 8; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      cout = carry[8];
   end

endmodule

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier with valid/ready on both sides.
// One RCA8 add per cycle; the 16-bit product accumulates in the {acc, q} register pair.
module mul8_seq
   import mul8_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   mul8_seq_if.slave  bus
);

   state_e         state_q, state_d;
   logic [Width-1:0] m_q, m_d;
   logic [Width-1:0] acc_q, acc_d;
   logic [Width-1:0] q_q, q_d;
   logic [2:0]       count_q, count_d;

   logic             add_cout;
   logic [Width-1:0] add_sum;
   logic [Width-1:0] add_b;

   logic in_ready, out_valid, busy;

   assign add_b = q_q[0] ? m_q : '0;

   mul8_seq_rca8 u_rca8 (
      .cout (add_cout),
      .sum  (add_sum),
      .a    (acc_q),
      .b    (add_b),
      .cin  (1'b0)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      count_d   = count_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;

      case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               m_d     = bus.a;
               q_d     = bus.b;
               acc_d   = '0;
               count_d = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            busy    = 1'b1;
            // 9-bit sum shifts right into the pair; its LSB becomes a finished product bit.
            acc_d   = {add_cout, add_sum[Width-1:1]};
            q_d     = {add_sum[0], q_q[Width-1:1]};
            count_d = count_q + 3'd1;
            if (count_q == LastStep) begin
               state_d = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.product   = {acc_q, q_q};

endmodule
